prog_clk_div: RTL and testbench

Runtime-programmable integer clock divider for the DFE rate-change chain: it divides `clk_in` by a ratio D loaded at run time and produces two outputs. `clk_out` is a registered divided clock. `clk_en_pulse` is a one-cycle enable strobe that the decimation stages use as a clock enable. New ratios are applied glitch-free, only at period boundaries, and `en` stops the output cleanly at the end of a period.

---
 rtl/prog_clk_div_pkg.sv | 13 +
 rtl/prog_clk_div_if.sv | 23 ++
 rtl/prog_clk_div_ratio_reg.sv | 52 +++++
 rtl/prog_clk_div.sv | 76 +++++++
 tb/tb_prog_clk_div.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/prog_clk_div_pkg.sv
// Shared types and helpers for the DFE clock-divider blocks.
package dfe_clk_pkg;

   localparam int CNT_W_DEF = 8;

   typedef enum logic {STOPPED = 1'b0, RUN = 1'b1} state_e;

   // Number of high cycles per period; D=1 stays high continuously.
   function automatic logic [31:0] div_high_len(input logic [31:0] d);
      return (d == 32'd1) ? 32'd1 : (d >> 1);
   endfunction

endpackage

// File: rtl/prog_clk_div_if.sv
// Control/status bundle between a ratio programmer and prog_clk_div.
interface prog_clk_div_if #(
   parameter int CNT_W = dfe_clk_pkg::CNT_W_DEF
);
   logic             en;
   logic [CNT_W-1:0] div_val;
   logic             div_load;
   logic             div_busy;
   logic             div_err;
   logic [CNT_W-1:0] div_active;
   logic             clk_out;
   logic             clk_en_pulse;

   modport master (
      output en, div_val, div_load,
      input  div_busy, div_err, div_active, clk_out, clk_en_pulse
   );

   modport slave (
      input  en, div_val, div_load,
      output div_busy, div_err, div_active, clk_out, clk_en_pulse
   );
endinterface

// File: rtl/prog_clk_div_ratio_reg.sv
// Pending/active divide-ratio registers with zero-reject and busy tracking.
module div_ratio_reg
   import dfe_clk_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DEFAULT_DIV = 3
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_val,
   input  logic             i_bound,
   output logic             o_busy,
   output logic             o_err,
   output logic [CNT_W-1:0] o_active
);

   logic [CNT_W-1:0] r_pend;
   logic [CNT_W-1:0] r_active;
   logic             r_busy;
   logic             r_err;
   logic             w_apply;
   logic             w_zero;

   assign w_zero  = (i_val == '0);
   // Only a value already pending before this edge can be applied here.
   assign w_apply = i_bound && r_busy;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_pend   <= CNT_W'(DEFAULT_DIV);
         r_active <= CNT_W'(DEFAULT_DIV);
         r_busy   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_err <= i_load && w_zero;
         if (w_apply)
            r_active <= r_pend;
         if (i_load && !w_zero) begin
            r_pend <= i_val;
            r_busy <= 1'b1;
         end else if (w_apply) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_busy   = r_busy;
   assign o_err    = r_err;
   assign o_active = r_active;

endmodule

// File: rtl/prog_clk_div.sv
// Runtime-programmable integer clock divider: registered divided clock plus
// a one-cycle enable strobe at the start of every output period.
module prog_clk_div
   import dfe_clk_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DEFAULT_DIV = 3
) (
   input  logic           clk_in,
   input  logic           rst_n,
   prog_clk_div_if.slave  bus
);

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_clk_out;
   logic             r_pulse;

   logic [CNT_W-1:0] w_active;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [31:0]      w_hi;
   logic             w_last;
   logic             w_bound;

   assign w_cnt_inc = r_cnt + CNT_W'(1);
   assign w_hi      = div_high_len(32'(w_active));
   assign w_last    = (r_cnt == w_active - CNT_W'(1));
   // New ratios land either while idle or on the edge that closes a period.
   assign w_bound   = (r_state == STOPPED) || w_last;

   div_ratio_reg #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_ratio (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .i_load   (bus.div_load),
      .i_val    (bus.div_val),
      .i_bound  (w_bound),
      .o_busy   (bus.div_busy),
      .o_err    (bus.div_err),
      .o_active (w_active)
   );

   // Counter=0 always drives clk_out high (H>=1 for every legal D), so the
   // freshly applied ratio only matters from the second cycle on.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= STOPPED;
         r_cnt     <= '0;
         r_clk_out <= 1'b0;
         r_pulse   <= 1'b0;
      end else if (r_state == STOPPED) begin
         r_cnt     <= '0;
         r_clk_out <= bus.en;
         r_pulse   <= bus.en;
         if (bus.en)
            r_state <= RUN;
      end else if (w_last) begin
         r_cnt     <= '0;
         r_clk_out <= bus.en;
         r_pulse   <= bus.en;
         if (!bus.en)
            r_state <= STOPPED;
      end else begin
         r_cnt     <= w_cnt_inc;
         r_clk_out <= (32'(w_cnt_inc) < w_hi);
         r_pulse   <= 1'b0;
      end
   end

   assign bus.div_active   = w_active;
   assign bus.clk_out      = r_clk_out;
   assign bus.clk_en_pulse = r_pulse;

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed bench for prog_clk_div: vector table plus reset and D=255 sequences.
module tb_prog_clk_div;

   typedef struct packed {
      logic       en;
      logic       ld;
      logic [7:0] val;
      logic       ck;
      logic       pu;
      logic       bz;
      logic       er;
      logic [7:0] act;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   vec_t q[$];

   prog_clk_div_if #(.CNT_W(8)) bus ();

   prog_clk_div #(
      .CNT_W       (8),
      .DEFAULT_DIV (3)
   ) dut (
      .clk_in (clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic en, input logic ld, input logic [7:0] val,
                      input logic ck, input logic pu, input logic bz,
                      input logic er, input logic [7:0] act);
      q.push_back({en, ld, val, ck, pu, bz, er, act});
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.en       = 1'b0;
      bus.div_load = 1'b0;
      bus.div_val  = '0;
      step();
      step();
      chk("rst clk_out", bus.clk_out, 0);
      chk("rst pulse", bus.clk_en_pulse, 0);
      chk("rst busy", bus.div_busy, 0);
      chk("rst err", bus.div_err, 0);
      chk("rst active", bus.div_active, 3);
      rst_n = 1'b1;

      //  en ld val  ck pu bz er act
      add(0, 0, 0,   0, 0, 0, 0, 3);
      add(1, 0, 0,   1, 1, 0, 0, 3);   // start-up latency 1
      add(1, 0, 0,   0, 0, 0, 0, 3);
      add(1, 0, 0,   0, 0, 0, 0, 3);
      add(1, 0, 0,   1, 1, 0, 0, 3);
      add(1, 1, 4,   0, 0, 1, 0, 3);   // load 4 -> counter 1
      add(1, 0, 0,   0, 0, 1, 0, 3);
      add(1, 0, 0,   1, 1, 0, 0, 4);
      add(1, 0, 0,   1, 0, 0, 0, 4);
      add(1, 0, 0,   0, 0, 0, 0, 4);
      add(1, 0, 0,   0, 0, 0, 0, 4);
      add(1, 0, 0,   1, 1, 0, 0, 4);
      add(1, 1, 5,   1, 0, 1, 0, 4);   // load 5 then 2: last wins
      add(1, 1, 2,   0, 0, 1, 0, 4);
      add(1, 0, 0,   0, 0, 1, 0, 4);
      add(1, 0, 0,   1, 1, 0, 0, 2);
      add(1, 0, 0,   0, 0, 0, 0, 2);
      add(1, 0, 0,   1, 1, 0, 0, 2);
      add(1, 1, 0,   0, 0, 0, 1, 2);   // zero rejected
      add(1, 0, 0,   1, 1, 0, 0, 2);
      add(1, 1, 1,   0, 0, 1, 0, 2);   // D=1
      add(1, 0, 0,   1, 1, 0, 0, 1);
      add(1, 0, 0,   1, 1, 0, 0, 1);
      add(1, 0, 0,   1, 1, 0, 0, 1);
      add(1, 0, 0,   1, 1, 0, 0, 1);
      add(0, 0, 0,   0, 0, 0, 0, 1);
      add(0, 0, 0,   0, 0, 0, 0, 1);
      add(0, 1, 4,   0, 0, 1, 0, 1);   // load while stopped
      add(0, 0, 0,   0, 0, 0, 0, 4);
      add(1, 0, 0,   1, 1, 0, 0, 4);
      add(1, 0, 0,   1, 0, 0, 0, 4);
      add(0, 0, 0,   0, 0, 0, 0, 4);   // en drops at counter 1
      add(0, 0, 0,   0, 0, 0, 0, 4);
      add(0, 0, 0,   0, 0, 0, 0, 4);
      add(0, 0, 0,   0, 0, 0, 0, 4);
      add(1, 0, 0,   1, 1, 0, 0, 4);   // restart latency 1
      add(1, 0, 0,   1, 0, 0, 0, 4);
      add(1, 0, 0,   0, 0, 0, 0, 4);
      add(1, 0, 0,   0, 0, 0, 0, 4);
      add(1, 1, 3,   1, 1, 1, 0, 4);   // load on boundary edge: deferred
      add(1, 0, 0,   1, 0, 1, 0, 4);
      add(1, 0, 0,   0, 0, 1, 0, 4);
      add(1, 0, 0,   0, 0, 1, 0, 4);
      add(1, 0, 0,   1, 1, 0, 0, 3);
      add(1, 0, 0,   0, 0, 0, 0, 3);

      for (int i = 0; i < q.size(); i++) begin
         bus.en       = q[i].en;
         bus.div_load = q[i].ld;
         bus.div_val  = q[i].val;
         step();
         chk($sformatf("v%0d clk_out", i), bus.clk_out, q[i].ck);
         chk($sformatf("v%0d pulse", i), bus.clk_en_pulse, q[i].pu);
         chk($sformatf("v%0d busy", i), bus.div_busy, q[i].bz);
         chk($sformatf("v%0d err", i), bus.div_err, q[i].er);
         chk($sformatf("v%0d active", i), bus.div_active, q[i].act);
      end

      // Mid-period async reset with a pending value outstanding.
      bus.div_load = 1'b1;
      bus.div_val  = 8'd7;
      step();
      chk("pre-rst busy", bus.div_busy, 1);
      bus.div_val  = 8'd9;
      step();
      chk("pre-rst active7", bus.div_active, 7);
      chk("pre-rst busy9", bus.div_busy, 1);
      bus.div_load = 1'b0;
      step();
      chk("pre-rst clk_out", bus.clk_out, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("async rst clk_out", bus.clk_out, 0);
      chk("async rst pulse", bus.clk_en_pulse, 0);
      chk("async rst busy", bus.div_busy, 0);
      chk("async rst err", bus.div_err, 0);
      chk("async rst active", bus.div_active, 3);
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("post-rst c%0d clk_out", c), bus.clk_out, (c % 3) == 0);
         chk($sformatf("post-rst c%0d pulse", c), bus.clk_en_pulse, (c % 3) == 0);
         chk($sformatf("post-rst c%0d active", c), bus.div_active, 3);
      end

      // Stop, program D=255, run two full periods.
      bus.en = 1'b0;
      for (int c = 0; c < 3; c++) step();
      bus.div_load = 1'b1;
      bus.div_val  = 8'd255;
      step();
      bus.div_load = 1'b0;
      step();
      chk("d255 active", bus.div_active, 255);
      chk("d255 busy", bus.div_busy, 0);
      chk("d255 stopped clk_out", bus.clk_out, 0);
      bus.en = 1'b1;
      for (int c = 0; c < 510; c++) begin
         step();
         chk($sformatf("d255 c%0d clk_out", c), bus.clk_out, (c % 255) < 127);
         chk($sformatf("d255 c%0d pulse", c), bus.clk_en_pulse, (c % 255) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
